// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache: combinational hit path,
// 4-word line fill over a request/valid memory handshake on a miss.
module icache_ctrl #(
   parameter int unsigned NUM_SETS       = 8,
   parameter int unsigned WORDS_PER_LINE = 4,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rd_en,
   input  logic [15:0]      addr,
   input  logic             inval,
   output logic [15:0]      instr,
   output logic             hit,
   output logic             stall,
   output logic             mem_re,
   output logic [15:0]      mem_addr,
   input  logic [15:0]      mem_rdata,
   input  logic             mem_rvalid,
   output logic [CNT_W-1:0] miss_cnt
);

   localparam int unsigned IDX_W = $clog2(NUM_SETS);
   localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
   localparam int unsigned TAG_W = 16 - IDX_W - OFF_W;

   typedef enum logic {IDLE, FILL} state_t;

   state_t state, state_next;

   logic [NUM_SETS-1:0] valid;
   logic [TAG_W-1:0]    tag_arr  [NUM_SETS];
   logic [15:0]         data_arr [NUM_SETS*WORDS_PER_LINE];

   logic [OFF_W-1:0] off;
   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;

   logic [TAG_W-1:0] fill_tag;
   logic [IDX_W-1:0] fill_idx;
   logic [OFF_W-1:0] word_cnt;

   logic miss_start;
   logic fill_last;

   assign off = addr[OFF_W-1:0];
   assign idx = addr[IDX_W+OFF_W-1:OFF_W];
   assign tag = addr[15:IDX_W+OFF_W];

   always_comb begin
      state_next = state;
      hit        = 1'b0;
      instr      = '0;
      miss_start = 1'b0;
      fill_last  = 1'b0;

      if (rd_en && (state == IDLE) && valid[idx] && (tag_arr[idx] == tag))
         hit = 1'b1;
      if (hit)
         instr = data_arr[{idx, off}];
      stall = (rd_en && !hit) || (state != IDLE);

      case (state)
         IDLE: begin
            // inval in the same cycle suppresses miss entry
            if (rd_en && !hit && !inval) begin
               miss_start = 1'b1;
               state_next = FILL;
            end
         end
         FILL: begin
            fill_last = mem_rvalid && (word_cnt == OFF_W'(WORDS_PER_LINE - 1));
            if (inval || fill_last)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid    <= '0;
         word_cnt <= '0;
         miss_cnt <= '0;
         mem_re   <= 1'b0;
         mem_addr <= '0;
         fill_tag <= '0;
         fill_idx <= '0;
      end else begin
         if (miss_start) begin
            fill_tag <= tag;
            fill_idx <= idx;
            word_cnt <= '0;
            mem_re   <= 1'b1;
            mem_addr <= {tag, idx, {OFF_W{1'b0}}};
            if (miss_cnt != '1)
               miss_cnt <= miss_cnt + 1'b1;
         end else if (state == FILL) begin
            if (inval) begin
               word_cnt <= '0;
               mem_re   <= 1'b0;
            end else if (mem_rvalid) begin
               word_cnt <= word_cnt + 1'b1;
               mem_addr <= {fill_tag, fill_idx, OFF_W'(word_cnt + 1'b1)};
               if (fill_last)
                  mem_re <= 1'b0;
            end
         end

         // inval takes priority so a line completing in the same cycle stays invalid
         if (inval)
            valid <= '0;
         else if (fill_last)
            valid[fill_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if ((state == FILL) && mem_rvalid)
         data_arr[{fill_idx, word_cnt}] <= mem_rdata;
      if (fill_last)
         tag_arr[fill_idx] <= fill_tag;
   end

endmodule
